// File: rtl/damage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : damage_pkg
// Description : Shared types and constants for the boss/character damage
//               arbiter: FSM state enum, grant encoding, default damage
//               values and saturating-subtract helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package damage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Grant encoding presented on the grant output
    localparam logic [1:0] GNT_NONE  = 2'd0;
    localparam logic [1:0] GNT_MELEE = 2'd1;
    localparam logic [1:0] GNT_PROJ  = 2'd2;

    localparam logic [6:0] DEF_BOSS_HP_MAX = 7'd100;
    localparam logic [6:0] DEF_MELEE_DMG   = 7'd3;
    localparam logic [6:0] DEF_PROJ_DMG    = 7'd1;
    localparam logic [3:0] DEF_CONTACT_DMG = 4'd1;
    localparam logic [5:0] DEF_IFRAMES     = 6'd30;

    function automatic logic [6:0] sat_sub7(input logic [6:0] a, input logic [6:0] b);
        return (a > b) ? (a - b) : 7'd0;
    endfunction

    function automatic logic [3:0] sat_sub4(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : 4'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter with a 1-deep pending flag per
//               source (melee, projectile). Grant is decoded from the
//               registered flags; a tie goes to the source not granted last.
// Ports       : clk, rst         - clock, async active-high reset
//               i_en             - flags may hold/set; when low they clear
//               i_gnt_en         - grants may be issued this cycle
//               i_req_melee/proj - one-cycle request pulses
//               o_grant          - GNT_NONE / GNT_MELEE / GNT_PROJ
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import damage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_gnt_en,
    input  logic       i_req_melee,
    input  logic       i_req_proj,
    output logic [1:0] o_grant
);

    logic       r_pend_melee;
    logic       r_pend_proj;
    logic       r_ptr_proj;     // 1: projectile wins the next tie
    logic [1:0] w_grant;

    always_comb begin
        w_grant = GNT_NONE;
        if (i_gnt_en) begin
            if (r_pend_melee && r_pend_proj)
                w_grant = r_ptr_proj ? GNT_PROJ : GNT_MELEE;
            else if (r_pend_melee)
                w_grant = GNT_MELEE;
            else if (r_pend_proj)
                w_grant = GNT_PROJ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_melee <= 1'b0;
            r_pend_proj  <= 1'b0;
            r_ptr_proj   <= 1'b0;
        end else begin
            if (i_en) begin
                // A fresh pulse on the grant edge keeps the flag set; a
                // pulse onto an ungranted flag merges into it.
                r_pend_melee <= (r_pend_melee && (w_grant != GNT_MELEE)) || i_req_melee;
                r_pend_proj  <= (r_pend_proj  && (w_grant != GNT_PROJ))  || i_req_proj;
            end else begin
                r_pend_melee <= 1'b0;
                r_pend_proj  <= 1'b0;
            end
            if (w_grant == GNT_MELEE)
                r_ptr_proj <= 1'b1;
            else if (w_grant == GNT_PROJ)
                r_ptr_proj <= 1'b0;
        end
    end

    assign o_grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/damage_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : damage_arbiter
// Description : Game damage controller. Melee/projectile hits share the boss
//               health counter through a round-robin arbiter; boss contact
//               damages the character, followed by an i-frame window.
// Ports       : clk, rst            - clock, async active-high reset
//               game_start          - reload health counters
//               game_active         - gameplay running
//               frame_tick          - one pulse per frame (i-frame timing)
//               char_hp             - character max health
//               projectile_hit, melee_hit, contact_hit - hit requests
//               boss_hp, current_health - health counters
//               boss_alive, char_invuln - status decodes
//               grant               - boss damage source this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module damage_arbiter
    import damage_pkg::*;
#(
    parameter logic [6:0] BOSS_HP_MAX = DEF_BOSS_HP_MAX,
    parameter logic [6:0] MELEE_DMG   = DEF_MELEE_DMG,
    parameter logic [6:0] PROJ_DMG    = DEF_PROJ_DMG,
    parameter logic [3:0] CONTACT_DMG = DEF_CONTACT_DMG,
    parameter logic [5:0] IFRAMES     = DEF_IFRAMES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_start,
    input  logic       game_active,
    input  logic       frame_tick,
    input  logic [3:0] char_hp,
    input  logic       projectile_hit,
    input  logic       melee_hit,
    input  logic       contact_hit,
    output logic [6:0] boss_hp,
    output logic [3:0] current_health,
    output logic       boss_alive,
    output logic       char_invuln,
    output logic [1:0] grant
);

    state_t     r_state;
    logic [6:0] r_boss_hp;
    logic [3:0] r_char_hp;
    logic [5:0] r_iframe;

    logic       w_run;
    logic [1:0] w_grant;
    logic [6:0] w_dmg;
    logic [6:0] w_boss_next;
    logic       w_contact;
    logic [3:0] w_char_next;
    logic       w_end;

    // Gameplay edge: hits count only in RUN with the game active and no
    // reload on this edge.
    assign w_run       = (r_state == ST_RUN) && game_active && !game_start;
    assign w_dmg       = (w_grant == GNT_MELEE) ? MELEE_DMG :
                         (w_grant == GNT_PROJ)  ? PROJ_DMG  : 7'd0;
    assign w_boss_next = sat_sub7(r_boss_hp, w_dmg);
    assign w_contact   = w_run && contact_hit && (r_iframe == 6'd0);
    assign w_char_next = w_contact ? sat_sub4(r_char_hp, CONTACT_DMG) : r_char_hp;
    assign w_end       = (w_boss_next == 7'd0) || (w_char_next == 4'd0);

    rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_run && !w_end),   // flags drop as the game leaves RUN
        .i_gnt_en    (w_run),
        .i_req_melee (melee_hit),
        .i_req_proj  (projectile_hit),
        .o_grant     (w_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_boss_hp <= 7'd0;
            r_char_hp <= 4'd0;
            r_iframe  <= 6'd0;
        end else if (game_start) begin
            r_boss_hp <= BOSS_HP_MAX;
            r_char_hp <= char_hp;
            r_iframe  <= 6'd0;
            case (r_state)
                ST_IDLE: r_state <= ST_RUN;
                ST_RUN:  r_state <= game_active ? ST_RUN  : ST_IDLE;
                ST_OVER: r_state <= game_active ? ST_OVER : ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end else begin
            if (w_contact)
                r_iframe <= IFRAMES;
            else if (frame_tick && (r_iframe != 6'd0))
                r_iframe <= r_iframe - 6'd1;

            case (r_state)
                ST_IDLE: r_state <= ST_IDLE;
                ST_RUN: begin
                    if (!game_active) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_boss_hp <= w_boss_next;
                        r_char_hp <= w_char_next;
                        if (w_end)
                            r_state <= ST_OVER;
                    end
                end
                ST_OVER: begin
                    if (!game_active)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign boss_hp        = r_boss_hp;
    assign current_health = r_char_hp;
    assign boss_alive     = (r_boss_hp != 7'd0);
    assign char_invuln    = (r_iframe != 6'd0);
    assign grant          = w_grant;

endmodule
`default_nettype wire

// File: tb/tb_damage_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_damage_arbiter
// Description : Self-checking bench for damage_arbiter. A behavioural game
//               model predicts grants (queued with their cycle number and
//               the boss health they act on) and health/status after every
//               edge; a monitor pops and compares grants independently.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_damage_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       game_start, game_active, frame_tick;
    logic [3:0] char_hp;
    logic       projectile_hit, melee_hit, contact_hit;
    logic [6:0] boss_hp;
    logic [3:0] current_health;
    logic       boss_alive, char_invuln;
    logic [1:0] grant;

    damage_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .game_start     (game_start),
        .game_active    (game_active),
        .frame_tick     (frame_tick),
        .char_hp        (char_hp),
        .projectile_hit (projectile_hit),
        .melee_hit      (melee_hit),
        .contact_hit    (contact_hit),
        .boss_hp        (boss_hp),
        .current_health (current_health),
        .boss_alive     (boss_alive),
        .char_invuln    (char_invuln),
        .grant          (grant)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; int gnt; int boss;} exp_t;
    exp_t sbq[$];

    // Game model: 0 idle, 1 running, 2 over. m_last = source granted last
    // (2 at reset so melee wins the first tie).
    int m_state, m_boss, m_hp, m_ifr, m_last;
    bit m_pm, m_pp;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_boss = 0; m_hp = 0; m_ifr = 0; m_last = 2;
        m_pm = 0; m_pp = 0;
    endtask

    task automatic check_status();
        check("boss_hp", int'(boss_hp), m_boss);
        check("health", int'(current_health), m_hp);
        check("boss_alive", int'(boss_alive), int'(m_boss != 0));
        check("invuln", int'(char_invuln), int'(m_ifr != 0));
    endtask

    // Monitor: compares grants whenever one is expected or presented.
    always @(negedge clk) begin
        if (!rst) begin
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                exp_t e;
                e = sbq.pop_front();
                check("grant", int'(grant), e.gnt);
                check("boss_at_grant", int'(boss_hp), e.boss);
            end else if (grant != 2'd0) begin
                check("unexpected_grant", int'(grant), 0);
            end
        end
    end

    // One clock of stimulus; called at posedge+1.
    task automatic step(input bit gs, input bit ga, input bit ft, input bit ch,
                        input bit mh, input bit ph, input int hpv);
        bit run, cnow, endg;
        int g, dmg, boss_n, hp_n;
        game_start = gs; game_active = ga; frame_tick = ft; contact_hit = ch;
        melee_hit = mh; projectile_hit = ph; char_hp = 4'(hpv);

        run = (m_state == 1) && ga && !gs;
        g = 0;
        if (run) begin
            if (m_pm && m_pp) g = (m_last == 1) ? 2 : 1;
            else if (m_pm)    g = 1;
            else if (m_pp)    g = 2;
        end
        if (g != 0) sbq.push_back('{cyc, g, m_boss});

        dmg    = (g == 1) ? 3 : (g == 2) ? 1 : 0;
        boss_n = (m_boss > dmg) ? m_boss - dmg : 0;
        cnow   = run && ch && (m_ifr == 0);
        hp_n   = cnow ? ((m_hp > 1) ? m_hp - 1 : 0) : m_hp;
        endg   = run && (boss_n == 0 || hp_n == 0);

        @(posedge clk);
        #1;
        m_pm = (run && !endg) ? ((m_pm && g != 1) || mh) : 0;
        m_pp = (run && !endg) ? ((m_pp && g != 2) || ph) : 0;
        if (g != 0) m_last = g;
        if (gs)             m_ifr = 0;
        else if (cnow)      m_ifr = 30;
        else if (ft && m_ifr > 0) m_ifr--;
        if (gs) begin
            m_boss = 100; m_hp = hpv;
            if (m_state == 0)      m_state = 1;
            else if (!ga)          m_state = 0;
        end else if (m_state == 1) begin
            if (!ga) m_state = 0;
            else begin
                m_boss = boss_n; m_hp = hp_n;
                if (endg) m_state = 2;
            end
        end else if (m_state == 2 && !ga) begin
            m_state = 0;
        end
        check_status();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, nloop;
        rst = 1'b1;
        game_start = 0; game_active = 0; frame_tick = 0; char_hp = 4'd0;
        projectile_hit = 0; melee_hit = 0; contact_hit = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_status();
        check("reset_grant", int'(grant), 0);
        rst = 1'b0;

        // Game start with an 8-point character.
        step(1, 1, 0, 0, 0, 0, 8);
        check("start_boss", int'(boss_hp), 100);
        check("start_health", int'(current_health), 8);

        // Simultaneous melee and projectile: melee first, then projectile.
        step(0, 1, 0, 0, 1, 1, 8);
        idle(1);
        check("rr_boss_97", int'(boss_hp), 97);
        idle(2);
        check("rr_boss_96", int'(boss_hp), 96);

        // Contact held for 40 frame ticks (one every 3 clocks).
        ticks = 0;
        while (ticks < 40) begin
            for (int k = 0; k < 2; k++) step(0, 1, 0, 1, 0, 0, 8);
            step(0, 1, 1, 1, 0, 0, 8);
            ticks++;
        end
        step(0, 1, 0, 0, 0, 0, 8);
        check("contact_two_hits", int'(current_health), 6);

        // Three back-to-back melee pulses, some against a pending projectile.
        step(0, 1, 0, 0, 1, 1, 8);
        step(0, 1, 0, 0, 1, 0, 8);
        step(0, 1, 0, 0, 1, 0, 8);
        idle(4);

        // Walk the boss down to exactly 2, then finish it with melee.
        nloop = 0;
        while (m_boss > 10 && nloop < 60) begin step(0, 1, 0, 0, 1, 0, 8); nloop++; end
        idle(3);
        nloop = 0;
        while (m_boss >= 5 && nloop < 10) begin step(0, 1, 0, 0, 1, 0, 8); idle(2); nloop++; end
        nloop = 0;
        while (m_boss > 2 && nloop < 10) begin step(0, 1, 0, 0, 0, 1, 8); idle(2); nloop++; end
        check("boss_at_2", int'(boss_hp), 2);
        step(0, 1, 0, 0, 1, 0, 8);
        idle(2);
        check("boss_sat_0", int'(boss_hp), 0);
        check("boss_dead", int'(boss_alive), 0);
        step(0, 1, 0, 0, 1, 1, 8);
        idle(2);
        check("over_ignores_hits", int'(boss_hp), 0);
        step(0, 0, 0, 0, 0, 0, 8);

        // Randomized play.
        for (int i = 0; i < 1500; i++) begin
            bit gs, ga;
            gs = ($urandom_range(0, 59) == 0) || (m_state == 0 && $urandom_range(0, 7) == 0);
            ga = (m_state == 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) != 0);
            step(gs, ga, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 15)));
        end

        // Reset while both flags are pending.
        step(1, 1, 0, 0, 0, 0, 8);
        step(0, 1, 0, 0, 1, 1, 8);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_status();
        check("async_rst_grant", int'(grant), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);

        check("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/damage_arbiter.md
DAMAGE_ARBITER -- requirements
Module: damage_arbiter

Interface
REQ-001 Parameter: BOSS_HP_MAX, 7'd100, boss hit points loaded at game start.
REQ-002 Parameter: MELEE_DMG, 7'd3, boss damage per melee grant.
REQ-003 Parameter: PROJ_DMG, 7'd1, boss damage per projectile grant.
REQ-004 Parameter: CONTACT_DMG, 4'd1, character damage per contact grant.
REQ-005 Parameter: IFRAMES, 6'd30, character invulnerability length in frame_tick pulses.
REQ-006 Port: clk  input  1  system clock; the only clock.
REQ-007 Port: rst  input  1  reset, asynchronous, active-high.
REQ-008 Port: game_start  input  1  one-cycle pulse; reload both health counters.
REQ-009 Port: game_active  input  1  high while gameplay runs; hits are ignored when low.
REQ-010 Port: frame_tick  input  1  one-cycle pulse per frame.
REQ-011 Port: char_hp  input  4  character maximum health for the selected class.
REQ-012 Port: projectile_hit  input  1  one-cycle request: projectile struck the boss.
REQ-013 Port: melee_hit  input  1  one-cycle request: melee struck the boss.
REQ-014 Port: contact_hit  input  1  level request: boss overlaps the character.
REQ-015 Port: boss_hp  output  7  current boss health.
REQ-016 Port: current_health  output  4  current character health.
REQ-017 Port: boss_alive  output  1  high while boss_hp is nonzero.
REQ-018 Port: char_invuln  output  1  high while the i-frame counter is nonzero.
REQ-019 Port: grant  output  2  source granted this cycle: 0 none, 1 melee, 2 projectile.

Function
REQ-020 FSM states: IDLE, RUN, OVER; all transitions occur on the clk edge.
REQ-021 IDLE -> RUN on game_start; game_start in any state reloads boss_hp=BOSS_HP_MAX, current_health=char_hp, clears pending flags and the i-frame counter.
REQ-022 RUN -> OVER when boss_hp or current_health becomes 0; OVER -> IDLE when game_active is low.
REQ-023 RUN -> IDLE when game_active falls, with health values held.
REQ-024 Each of melee and projectile has a 1-deep pending flag, set by its pulse in RUN; a pulse while the flag is already set coalesces and is lost.
REQ-025 The boss health counter is the shared resource: at most one boss grant per cycle, from the registered pending flags.
REQ-026 Round-robin arbitration: when both are pending, grant goes to the source not granted last; the round-robin pointer resets to favour melee.
REQ-027 A granted flag clears on the same edge the subtraction is applied, unless a new pulse of that source arrives on that edge (the flag then stays set).
REQ-028 Latency: an uncontested pulse sampled on edge k sets pending at k; grant is high during cycle k..k+1; boss_hp is updated on edge k+1.
REQ-029 Subtraction saturates at 0; no wrap-around.
REQ-030 Contact: in RUN, with contact_hit high and the i-frame counter 0, current_health decreases by CONTACT_DMG (saturating at 0) and the counter loads IFRAMES on the same edge.
REQ-031 The i-frame counter decrements by 1 on each frame_tick while nonzero; it is held otherwise.
REQ-032 A grant and a contact in the same cycle are both applied, since they target independent counters.
REQ-033 In IDLE and OVER: no grants, pending flags held at 0, hit inputs ignored.
REQ-034 boss_alive and char_invuln are combinational decodes of registered state.

Reset
REQ-035 On rst: state=IDLE, boss_hp=0, current_health=0, boss_alive=0, char_invuln=0, grant=0, pending flags=0, round-robin pointer=melee, i-frame counter=0.
REQ-036 Reset asserted mid-game aborts immediately, and any pending hits are discarded.

Structure
REQ-037 The state enum, grant encoding and default damage constants shall be placed in a shared package, damage_pkg.
REQ-038 The 2-way round-robin arbiter shall be a single sub-module, rr_arb2, holding the pending flags and the pointer.

Verification
REQ-039 Scenario 1: game_start with char_hp=4'd8 -> boss_hp=100, current_health=8 and state RUN on the next edge.
REQ-040 Scenario 2: melee_hit and projectile_hit pulsed in the same cycle -> grant=1, then grant=2 on consecutive cycles; boss_hp goes 100 -> 97 -> 96.
REQ-041 Scenario 3: contact_hit held high for 40 frame_ticks with IFRAMES=30 -> exactly 2 decrements, 8 -> 7 -> 6, with the second decrement on the 31st tick.
REQ-042 Scenario 4: boss_hp=2 and a melee grant -> boss_hp=0 (no wrap), boss_alive=0, state=OVER, and a further hit leaves boss_hp=0.
REQ-043 Scenario 5: three melee pulses on consecutive cycles while melee is pending -> coalescing per REQ-024/REQ-027 is verified by the number of 3-point decrements.
REQ-044 Scenario 6: rst asserted while both flags are pending -> all outputs equal their REQ-035 values asynchronously, and no grant follows release.
